// File: rtl/paddle_tracker.sv
// Purpose : multi-channel quadrature encoder tracker; saturating paddle position per channel.
// Latency : an {A,B} change meeting setup before edge k reaches POSITION/MOVED/FAULT at edge k+SYNC_STAGES+1.
// Backpres: none; inputs are sampled every cycle, outputs are registered levels and one-cycle pulses.
//
// Ports:
//   CLOCK, RESET     system clock; asynchronous active-high reset
//   A, B [CHANNELS]  raw encoder phases (asynchronous), bit i -> channel i
//   CENTER           one-cycle request: all channels to POS_MAX/2, clear FAULT and partial detents
//   POSITION         channel i at [i*POS_W +: POS_W]
//   MOVED            one-cycle pulse when a channel's POSITION changes
//   FAULT            sticky illegal-transition (both phases changed) flag, cleared by CENTER/RESET
// Optional feature: define PADDLE_ACCEL_EN to double the step for quick same-direction detents.
module paddle_tracker #(
    parameter int CHANNELS         = 2,
    parameter int POS_W            = 8,
    parameter int POS_MAX          = 200,
    parameter int EDGES_PER_DETENT = 4,
    parameter int STEP             = 8,
    parameter int SYNC_STAGES      = 2,
    parameter int ACCEL_WINDOW     = 50000
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic [CHANNELS-1:0]       A,
    input  logic [CHANNELS-1:0]       B,
    input  logic                      CENTER,
    output logic [CHANNELS*POS_W-1:0] POSITION,
    output logic [CHANNELS-1:0]       MOVED,
    output logic [CHANNELS-1:0]       FAULT
);
    localparam int CW  = $clog2(EDGES_PER_DETENT) + 1;
    localparam int PRW = $clog2(SYNC_STAGES + 2);

    localparam logic [PRW-1:0]       PRIME_DONE = PRW'(SYNC_STAGES + 1);
    localparam logic signed [CW-1:0] CNT_MAX    = CW'(EDGES_PER_DETENT - 1);
    localparam logic signed [CW-1:0] CNT_MIN    = -CNT_MAX;
    localparam logic signed [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [POS_W:0]       POS_MAX_W  = (POS_W + 1)'(POS_MAX);
    localparam logic [POS_W-1:0]     CENTER_POS = POS_W'(POS_MAX / 2);
    localparam logic [POS_W:0]       STEP_1X    = (POS_W + 1)'(STEP);
`ifdef PADDLE_ACCEL_EN
    localparam int                   TW         = $clog2(ACCEL_WINDOW + 1);
    localparam logic [TW-1:0]        WIN        = TW'(ACCEL_WINDOW);
    localparam logic [POS_W:0]       STEP_2X    = (POS_W + 1)'(2 * STEP);
`endif

    if (POS_MAX >= (1 << POS_W) || EDGES_PER_DETENT < 1 || SYNC_STAGES < 2 || ACCEL_WINDOW < 1)
    begin : g_bad_params
        $error("paddle_tracker: illegal parameter set");
    end

    // Decoding stays off until the synchroniser has flushed whatever it held at reset,
    // so the previous-state register starts from the real encoder position.
    logic [PRW-1:0] prime_q;
    logic           primed;

    assign primed = (prime_q == PRIME_DONE);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)        prime_q <= '0;
        else if (!primed) prime_q <= prime_q + 1'b1;
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]           sync_q [SYNC_STAGES];
        logic [1:0]           cur_ab, prev_q, cur_ph, prev_ph, delta;
        logic signed [CW-1:0] cnt_q, cnt_d;
        logic                 up_q, up_d, dn_q, dn_d, ill_q, ill_d;
        logic [POS_W:0]       step, sum_up;
        logic [POS_W-1:0]     pos_q, pos_d;
        logic                 moved_q, fault_q, fault_d;

        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 2'b00;
            end else begin
                sync_q[0] <= {A[ch], B[ch]};
                for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            end
        end

        // Gray {A,B} mapped to a 2-bit phase: forward rotation is phase+1, reverse phase-1,
        // and a phase difference of 2 means both bits flipped at once.
        assign cur_ab  = sync_q[SYNC_STAGES-1];
        assign cur_ph  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
        assign prev_ph = {prev_q[1], prev_q[1] ^ prev_q[0]};
        assign delta   = cur_ph - prev_ph;

        always_comb begin
            cnt_d = cnt_q;
            up_d  = 1'b0;
            dn_d  = 1'b0;
            ill_d = 1'b0;
            if (CENTER) begin
                cnt_d = '0;
            end else if (primed) begin
                case (delta)
                    2'd1: begin
                        if (cnt_q == CNT_MAX) begin
                            cnt_d = '0;
                            up_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    2'd3: begin
                        if (cnt_q == CNT_MIN) begin
                            cnt_d = '0;
                            dn_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    2'd2:    ill_d = 1'b1;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                prev_q <= 2'b00;
                cnt_q  <= '0;
                up_q   <= 1'b0;
                dn_q   <= 1'b0;
                ill_q  <= 1'b0;
            end else begin
                prev_q <= cur_ab;
                cnt_q  <= cnt_d;
                up_q   <= up_d;
                dn_q   <= dn_d;
                ill_q  <= ill_d;
            end
        end

`ifdef PADDLE_ACCEL_EN
        logic [TW-1:0] tmr_q;
        logic          last_up_q;

        always_comb begin
            step = STEP_1X;
            if (((up_q && last_up_q) || (dn_q && !last_up_q)) && (tmr_q < WIN)) step = STEP_2X;
        end

        // Timer parked at WIN means "expired": the next detent never accelerates.
        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                tmr_q     <= WIN;
                last_up_q <= 1'b0;
            end else if (CENTER) begin
                tmr_q     <= WIN;
            end else if (up_q || dn_q) begin
                tmr_q     <= '0;
                last_up_q <= up_q;
            end else if (tmr_q != WIN) begin
                tmr_q     <= tmr_q + 1'b1;
            end
        end
`else
        assign step = STEP_1X;
`endif

        // One bit of headroom so the up-sum cannot wrap before the clamp.
        always_comb begin
            sum_up  = {1'b0, pos_q} + step;
            pos_d   = pos_q;
            fault_d = fault_q;
            if (CENTER) begin
                pos_d   = CENTER_POS;
                fault_d = 1'b0;
            end else begin
                if (up_q)
                    pos_d = (sum_up > POS_MAX_W) ? POS_MAX_W[POS_W-1:0] : sum_up[POS_W-1:0];
                else if (dn_q)
                    pos_d = ({1'b0, pos_q} >= step) ? (pos_q - step[POS_W-1:0]) : '0;
                if (ill_q) fault_d = 1'b1;
            end
        end

        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                pos_q   <= '0;
                moved_q <= 1'b0;
                fault_q <= 1'b0;
            end else begin
                pos_q   <= pos_d;
                moved_q <= (pos_d != pos_q);
                fault_q <= fault_d;
            end
        end

        assign POSITION[ch*POS_W +: POS_W] = pos_q;
        assign MOVED[ch]                   = moved_q;
        assign FAULT[ch]                   = fault_q;
    end

endmodule
